// File: rtl/cache_ram.sv
// rtl/cache_ram.sv - single-port 1024x144 tag/data RAM with byte enables
//
// Backing store for the direct-mapped cache. Each word is laid out as
// {dirty[143], tag[142:128], line[127:0]}. Every word starts out all-zero,
// so the cache comes up with dirty=0 and tag=0 everywhere.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   async active-low reset; clears q only, never the array
//   address  in   word address used for both read and write
//   byteena  in   bit i enables write of data[8i+7:8i]
//   data     in   write data
//   wren     in   write strobe, active high
//   q        out  registered read data, one cycle after address
//
// A read happens every cycle. On a write cycle q returns the merged new
// word, i.e. enabled bytes from data and the rest from the stored word.
// In 4-state simulation an X address drops the write (the indexed store is
// ignored) and the read returns X, which is the behaviour we want there.

module cache_ram #(
  parameter int ADDR_W = 10,
  parameter int BYTES  = 18
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    address,
  input  logic [BYTES-1:0]     byteena,
  input  logic [8*BYTES-1:0]   data,
  input  logic                 wren,
  output logic [8*BYTES-1:0]   q
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WORD_W = 8 * BYTES;

  // Zero image doubles as the FPGA init contents.
  logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};

  logic [WORD_W-1:0] stored_word;
  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] rd_d;
  logic [WORD_W-1:0] rd_q;

  // Byte merge of the write data onto the currently stored word. The same
  // merged word feeds both the array and the output register, which gives
  // new-data read-during-write behaviour without a bypass mux later on.
  always_comb begin
    stored_word = mem_q[address];
    word_d      = stored_word;
    for (int i = 0; i < BYTES; i++) begin
      if (byteena[i]) begin
        word_d[8*i +: 8] = data[8*i +: 8];
      end
    end
    rd_d = wren ? word_d : stored_word;
  end

  // Array write. Gated by reset_n so that a write whose edge lands while
  // reset is asserted is dropped; the contents themselves are never reset.
  always_ff @(posedge clock) begin
    if (reset_n && wren) begin
      mem_q[address] <= word_d;
    end
  end

  // Output register: the only pipeline stage, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign q = rd_q;

endmodule

// File: tb/tb_cache_ram.sv
// tb/tb_cache_ram.sv - self-checking bench for cache_ram
module tb_cache_ram;

  localparam int ADDR_W = 10;
  localparam int BYTES  = 18;
  localparam int W      = 8 * BYTES;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                clock;
  logic                reset_n;
  logic [ADDR_W-1:0]   address;
  logic [BYTES-1:0]    byteena;
  logic [W-1:0]        data;
  logic                wren;
  logic [W-1:0]        q;

  cache_ram #(.ADDR_W(ADDR_W), .BYTES(BYTES)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .address (address),
    .byteena (byteena),
    .data    (data),
    .wren    (wren),
    .q       (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [BYTES-1:0]  be;
    logic [W-1:0]      d;
    logic              we;
    logic [W-1:0]      exp_q;
    string             name;
  } vec_t;

  vec_t tbl[$];

  logic [W-1:0] ref_mem [DEPTH];

  int n_checks;
  int n_pass;

  localparam logic [W-1:0] W1  = 144'h1234_DEADBEEF_00112233_44556677_8899AABB;
  localparam logic [W-1:0] P1  = 144'hFFFF_00000000_00000000_00000000_CAFEF00D;
  localparam logic [W-1:0] M1  = 144'hFFFF_DEADBEEF_00112233_44556677_CAFEF00D;
  localparam logic [W-1:0] TOP = 144'h8001_01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  // Reference: new word = (old AND NOT mask) OR (data AND mask), where the
  // mask has 0xFF in every enabled byte lane.
  function automatic logic [W-1:0] lane_mask(input logic [BYTES-1:0] be);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (be[i]) m = m | ({{(W-8){1'b0}}, 8'hFF} << (8 * i));
    end
    return m;
  endfunction

  function automatic logic [W-1:0] model_step(input logic [ADDR_W-1:0] a,
                                              input logic [BYTES-1:0] be,
                                              input logic [W-1:0] d,
                                              input logic we);
    logic [W-1:0] m;
    logic [W-1:0] nw;
    m  = lane_mask(be);
    nw = (ref_mem[a] & ~m) | (d & m);
    if (we) begin
      ref_mem[a] = nw;
      return nw;
    end
    return ref_mem[a];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: q=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, let the edge happen, sample 1 ns later.
  task automatic drive(input logic [ADDR_W-1:0] a, input logic [BYTES-1:0] be,
                       input logic [W-1:0] d, input logic we);
    address = a;
    byteena = be;
    data    = d;
    wren    = we;
    @(posedge clock);
    #1;
  endtask

  logic [W-1:0] exp_v;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    tbl.push_back('{addr: 10'd0,    be: 18'h00000, d: '0,   we: 1'b0, exp_q: '0,      name: "pwr_rd_0"});
    tbl.push_back('{addr: 10'd511,  be: 18'h00000, d: '0,   we: 1'b0, exp_q: '0,      name: "pwr_rd_511"});
    tbl.push_back('{addr: 10'd1023, be: 18'h00000, d: '0,   we: 1'b0, exp_q: '0,      name: "pwr_rd_1023"});
    tbl.push_back('{addr: 10'd5,    be: 18'h3FFFF, d: W1,   we: 1'b1, exp_q: W1,      name: "full_wr_5"});
    tbl.push_back('{addr: 10'd5,    be: 18'h00000, d: '0,   we: 1'b0, exp_q: W1,      name: "full_rd_5"});
    tbl.push_back('{addr: 10'd5,    be: 18'h3000F, d: P1,   we: 1'b1, exp_q: M1,      name: "merge_wr_5"});
    tbl.push_back('{addr: 10'd5,    be: 18'h00000, d: '0,   we: 1'b0, exp_q: M1,      name: "merge_rd_5"});
    tbl.push_back('{addr: 10'd9,    be: 18'h00001, d: ONES, we: 1'b1, exp_q: 144'hFF, name: "rdw_9"});
    tbl.push_back('{addr: 10'd9,    be: 18'h00000, d: '0,   we: 1'b0, exp_q: 144'hFF, name: "rd_9"});
    tbl.push_back('{addr: 10'd9,    be: 18'h00001, d: 144'hA5, we: 1'b1, exp_q: 144'hA5, name: "rdw_9_a5"});
    tbl.push_back('{addr: 10'd5,    be: 18'h00000, d: ONES, we: 1'b1, exp_q: M1,      name: "zero_mask_wr"});
    tbl.push_back('{addr: 10'd5,    be: 18'h00000, d: '0,   we: 1'b0, exp_q: M1,      name: "zero_mask_rd"});
    tbl.push_back('{addr: 10'd20,   be: 18'h00001, d: 144'h11,   we: 1'b1, exp_q: 144'h11,   name: "b2b_wr_a"});
    tbl.push_back('{addr: 10'd20,   be: 18'h00002, d: 144'h2200, we: 1'b1, exp_q: 144'h2211, name: "b2b_wr_b"});
    tbl.push_back('{addr: 10'd20,   be: 18'h00000, d: '0,   we: 1'b0, exp_q: 144'h2211, name: "b2b_rd"});
    tbl.push_back('{addr: 10'd1023, be: 18'h3FFFF, d: TOP,  we: 1'b1, exp_q: TOP,     name: "top_wr"});
    tbl.push_back('{addr: 10'd0,    be: 18'h00000, d: '0,   we: 1'b0, exp_q: '0,      name: "no_wrap_rd_0"});
    tbl.push_back('{addr: 10'd1023, be: 18'h00000, d: '0,   we: 1'b0, exp_q: TOP,     name: "top_rd"});

    reset_n = 1'b0;
    address = '0;
    byteena = '0;
    data    = '0;
    wren    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_q", q, '0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].addr, tbl[k].be, tbl[k].d, tbl[k].we);
      exp_v = model_step(tbl[k].addr, tbl[k].be, tbl[k].d, tbl[k].we);
      check(tbl[k].name, q, tbl[k].exp_q);
    end

    // Async reset: q non-zero, then reset between edges.
    drive(10'd5, '0, '0, 1'b0);
    check("pre_reset_q", q, M1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_q", q, '0);
    // Write attempted while reset held must be dropped.
    address = 10'd5;
    byteena = 18'h3FFFF;
    data    = '0;
    wren    = 1'b1;
    @(posedge clock);
    #1;
    check("reset_hold_q", q, '0);
    #2;
    reset_n = 1'b1;
    drive(10'd5, '0, '0, 1'b0);
    check("post_reset_rd_5", q, M1);

    // Randomized traffic concentrated on a few addresses plus the ends.
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [ADDR_W-1:0] a;
      logic [BYTES-1:0]  be;
      logic [W-1:0]      d;
      logic              we;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 10'd1023;
      else if (r == 1) a = 10'd0;
      else             a = ADDR_W'($urandom_range(0, 15));
      be = BYTES'($urandom);
      if ($urandom_range(0, 7) == 0) be = '0;
      for (int j = 0; j < W / 16; j++) d[16*j +: 16] = 16'($urandom);
      we = 1'($urandom_range(0, 1));
      drive(a, be, d, we);
      exp_v = model_step(a, be, d, we);
      check($sformatf("rand_%0d_a%0d", n, a), q, exp_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
